cmp_stream: RTL

- Parametrised, registered magnitude comparator with a valid/ready stream interface.
- Per transaction it compares two WIDTH-bit operands, unsigned or two's-complement (mode sampled with the operands).
- Returns one-hot eq/gt/lt flags one cycle after acceptance.
- Keeps saturating event counters for each outcome. It replaces the fixed 2-bit combinational compare in datapaths that need wider operands, backpressure and statistics.

---
 rtl/cmp_stream.sv | 66 ++++++
 1 files changed

// File: rtl/cmp_stream.sv
// cmp_stream: registered signed/unsigned magnitude comparator with valid/ready stream and saturating outcome counters
module cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_eq_b,
  output logic             a_gr_b,
  output logic             a_ls_b,
  input  logic             clr,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gr_cnt,
  output logic [CNT_W-1:0] ls_cnt
);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  logic             accept, eq, gt, lt;
  logic [WIDTH-1:0] ax, bx;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  // flipping the sign bit maps two's-complement order onto unsigned order
  assign ax = a ^ (sgn ? MSB : '0);
  assign bx = b ^ (sgn ? MSB : '0);
  assign eq = a == b;
  assign gt = ax > bx;
  assign lt = ~eq & ~gt;
  // output stage: load on accept, drop valid on consume without accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_eq_b    <= 1'b0;
      a_gr_b    <= 1'b0;
      a_ls_b    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a_eq_b    <= eq;
      a_gr_b    <= gt;
      a_ls_b    <= lt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // saturating outcome counters; clr beats a coincident accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt <= '0;
      gr_cnt <= '0;
      ls_cnt <= '0;
    end else if (clr) begin
      eq_cnt <= '0;
      gr_cnt <= '0;
      ls_cnt <= '0;
    end else if (accept) begin
      if (eq && ~&eq_cnt) eq_cnt <= eq_cnt + CNT_W'(1);
      if (gt && ~&gr_cnt) gr_cnt <= gr_cnt + CNT_W'(1);
      if (lt && ~&ls_cnt) ls_cnt <= ls_cnt + CNT_W'(1);
    end
  end
endmodule
